// File: rtl/mp_link_ctrl.sv
// Multiplayer link controller: a ready-exchange FSM in front of a UART byte
// interface, plus win/lose signalling between the two players.
// Optional build macro MP_LINK_RETX_EN: while LOST, the LOSE character is
// sent LOSE_REPEAT times, each one READY_PERIOD cycles after the previous
// acceptance. Without it, LOSE is sent exactly once.
// Transmit handshake: once o_tx_valid is raised, o_tx_valid and o_tx_data stay
// stable until a cycle with i_tx_ready=1 (acceptance). o_tx_valid then drops for
// at least one cycle. At most one character is ever outstanding. Only rst
// abandons an outstanding character.
module mp_link_ctrl #(
    parameter int              DATA_W       = 8,
    parameter logic [DATA_W-1:0] CHAR_READY = 8'h52,
    parameter logic [DATA_W-1:0] CHAR_LOSE  = 8'h4C,
    parameter int              READY_PERIOD = 100000,
    parameter int              LOSE_REPEAT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_multiplayer,
    input  logic              i_player_ready,
    input  logic              i_game_over,
    input  logic              i_restart,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_game_start,
    output logic              o_win,
    output logic              o_lose,
    output logic [2:0]        o_link_state,
    output logic [DATA_W-1:0] o_last_char
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEARCH = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_PLAY   = 3'd3;
    localparam logic [2:0] S_LOST   = 3'd4;
    localparam logic [2:0] S_WON    = 3'd5;

    localparam int CW = $clog2(READY_PERIOD);
    localparam logic [CW-1:0] PACE_RELOAD = CW'(READY_PERIOD - 1);

`ifdef MP_LINK_RETX_EN
    localparam int LOSE_N = LOSE_REPEAT;
`else
    // Single LOSE; the repeat count only matters with retransmission built in.
    localparam int LOSE_N = (LOSE_REPEAT >= 1) ? 1 : 1;
`endif
    localparam int LW = $clog2(LOSE_N + 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [CW-1:0]     r_pace;
    logic [CW-1:0]     w_pace_next;
    logic [LW-1:0]     r_lose_left;
    logic [LW-1:0]     w_lose_dec;
    logic [LW-1:0]     w_lose_left_next;
    logic              r_peer_seen;
    logic              r_own_sent;
    logic              r_restart_pend;
    logic              r_tx_valid;
    logic [DATA_W-1:0] r_tx_data;
    logic [DATA_W-1:0] r_last_char;
    logic              w_accept;
    logic              w_rx_ready;
    logic              w_rx_lose;
    logic              w_peer_next;
    logic              w_own_next;
    logic              w_launch;

    assign w_accept    = r_tx_valid && i_tx_ready;
    assign w_rx_ready  = i_rx_valid && (i_rx_data == CHAR_READY);
    assign w_rx_lose   = i_rx_valid && (i_rx_data == CHAR_LOSE);
    assign w_peer_next = r_peer_seen || ((r_state == S_SEARCH) && w_rx_ready);
    // Own READY only counts once the peer is known, including the same cycle.
    assign w_own_next  = r_own_sent || ((r_state == S_SEARCH) && w_accept &&
                         (r_tx_data == CHAR_READY) && w_peer_next);
    assign w_lose_dec  = (w_accept && (r_lose_left != '0)) ? r_lose_left - 1'b1 : r_lose_left;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic; multiplayer=0 overrides everything
    always_comb begin
        w_state_next = r_state;
        if (!i_multiplayer) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (i_player_ready) w_state_next = S_SEARCH;
                S_SEARCH: begin
                    if (!i_player_ready)                w_state_next = S_IDLE;
                    else if (w_peer_next && w_own_next) w_state_next = S_START;
                end
                S_START:  w_state_next = S_PLAY;
                S_PLAY: begin
                    if (i_game_over)    w_state_next = S_LOST;
                    else if (w_rx_lose) w_state_next = S_WON;
                end
                S_LOST:   if ((i_restart || r_restart_pend) && (w_lose_dec == '0)) w_state_next = S_IDLE;
                S_WON:    if (i_restart) w_state_next = S_IDLE;
                default:  w_state_next = S_IDLE;
            endcase
        end
    end

    // Pacing: reload on acceptance, count down to 0 and hold there
    always_comb begin
        w_pace_next = '0;
        if ((r_state == S_SEARCH) || (r_state == S_LOST)) begin
            if (w_accept)            w_pace_next = PACE_RELOAD;
            else if (r_pace != '0)   w_pace_next = r_pace - 1'b1;
        end
    end

    // Remaining LOSE sends: loaded on entry to LOST, cleared on leaving it
    always_comb begin
        w_lose_left_next = '0;
        if (w_state_next == S_LOST) begin
            if (r_state != S_LOST) w_lose_left_next = LW'(LOSE_N);
            else                   w_lose_left_next = w_lose_dec;
        end
    end

    // Start a new character only when the link is idle and pacing has expired
    assign w_launch = !r_tx_valid && (w_pace_next == '0) &&
                      ((w_state_next == S_SEARCH) ||
                       ((w_state_next == S_LOST) && (w_lose_left_next != '0)));

    // Datapath registers: tx handshake, pacing, exchange flags, received char
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_valid     <= 1'b0;
            r_tx_data      <= '0;
            r_pace         <= '0;
            r_lose_left    <= '0;
            r_peer_seen    <= 1'b0;
            r_own_sent     <= 1'b0;
            r_restart_pend <= 1'b0;
            r_last_char    <= '0;
        end else begin
            if (w_accept) begin
                r_tx_valid <= 1'b0;
            end else if (w_launch) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= (w_state_next == S_SEARCH) ? CHAR_READY : CHAR_LOSE;
            end
            r_pace         <= w_pace_next;
            r_lose_left    <= w_lose_left_next;
            r_peer_seen    <= (w_state_next == S_SEARCH) && w_peer_next;
            r_own_sent     <= (w_state_next == S_SEARCH) && w_own_next;
            r_restart_pend <= (w_state_next == S_LOST) &&
                              (r_restart_pend || ((r_state == S_LOST) && i_restart));
            if (i_rx_valid) r_last_char <= i_rx_data;
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        o_link_state = r_state;
        o_game_start = (r_state == S_START);
        o_win        = (r_state == S_WON);
        o_lose       = (r_state == S_LOST);
        o_tx_valid   = r_tx_valid;
        o_tx_data    = r_tx_data;
        o_last_char  = r_last_char;
    end

endmodule

// File: tb/tb_mp_link_ctrl.sv
// Directed bench for mp_link_ctrl with READY_PERIOD=8 and LOSE_REPEAT=3.
module tb_mp_link_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_multiplayer, i_player_ready, i_game_over, i_restart;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       o_game_start, o_win, o_lose;
    logic [2:0] o_link_state;
    logic [7:0] o_last_char;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tx_acc = 0;
    int lose_acc = 0;
    int lose_cyc_q[$];
    int base, vsum;

`ifdef MP_LINK_RETX_EN
    localparam int LOSE_EXP = 3;
`else
    localparam int LOSE_EXP = 1;
`endif

    mp_link_ctrl #(
        .DATA_W(8), .CHAR_READY(8'h52), .CHAR_LOSE(8'h4C),
        .READY_PERIOD(8), .LOSE_REPEAT(3)
    ) dut (
        .clk(clk), .rst(rst),
        .i_multiplayer(i_multiplayer), .i_player_ready(i_player_ready),
        .i_game_over(i_game_over), .i_restart(i_restart),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_game_start(o_game_start), .o_win(o_win), .o_lose(o_lose),
        .o_link_state(o_link_state), .o_last_char(o_last_char)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Handshake observer on the falling edge: inputs and outputs are settled
    always @(negedge clk) begin
        if (!rst && o_tx_valid && i_tx_ready) begin
            tx_acc++;
            if (o_tx_data == 8'h4C) begin
                lose_acc++;
                lose_cyc_q.push_back(cyc);
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (o_link_state !== s && n < budget) begin
            tick();
            n++;
        end
        check(tag, {29'd0, o_link_state}, {29'd0, s});
    endtask

    // Bring the link from IDLE into PLAY with a peer READY
    task automatic goto_play();
        i_tx_ready = 1'b1; i_multiplayer = 1'b1; i_player_ready = 1'b1;
        wait_state(3'd1, 20, "gp_search");
        i_rx_valid = 1'b1; i_rx_data = 8'h52;
        tick();
        i_rx_valid = 1'b0;
        wait_state(3'd3, 40, "gp_play");
    endtask

    initial begin
        rst = 1'b1; i_multiplayer = 1'b1; i_player_ready = 1'b1; i_game_over = 1'b0;
        i_restart = 1'b0; i_tx_ready = 1'b1; i_rx_data = 8'h00; i_rx_valid = 1'b0;
        repeat (3) tick();

        // reset values
        check("rst_state", o_link_state, 0);
        check("rst_tx", {o_tx_valid, o_tx_data}, 0);
        check("rst_flags", {o_game_start, o_win, o_lose}, 0);
        check("rst_last", o_last_char, 0);

        // first cycle after release is IDLE, then SEARCH with READY requested
        rst = 1'b0;
        check("rel_idle", o_link_state, 0);
        tick();
        check("srch_state", o_link_state, 1);
        check("srch_tx", {o_tx_valid, o_tx_data}, 9'h152);

        // READY every 8 cycles
        vsum = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            vsum += o_tx_valid;
        end
        check("pace_gap", vsum, 0);
        tick();
        check("pace_next", {o_tx_valid, o_tx_data}, 9'h152);
        tick();

        // peer READY arrives while waiting; start after our next accepted READY
        i_rx_valid = 1'b1; i_rx_data = 8'h52;
        tick();
        i_rx_valid = 1'b0;
        check("peer_last", o_last_char, 8'h52);
        check("peer_state", o_link_state, 1);
        repeat (6) tick();
        check("peer_tx", {o_tx_valid, o_tx_data}, 9'h152);
        tick();
        check("start_state", o_link_state, 2);
        check("start_pulse", o_game_start, 1);
        tick();
        check("play_state", o_link_state, 3);
        check("play_pulse", o_game_start, 0);

        // local loss with a stalled UART
        i_game_over = 1'b1; i_tx_ready = 1'b0;
        lose_cyc_q.delete();
        base = lose_acc;
        tick();
        i_game_over = 1'b0;
        check("lost_state", o_link_state, 4);
        check("lost_flag", o_lose, 1);
        check("lost_tx", {o_tx_valid, o_tx_data}, 9'h14C);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lose_hold", {o_tx_valid, o_tx_data}, 9'h14C);
        end
        i_tx_ready = 1'b1;
        tick();
        check("lose_acc_drop", o_tx_valid, 0);
        check("lose_stay", o_link_state, 4);
        repeat (25) tick();
        check("lose_count", lose_acc - base, LOSE_EXP);
        check("lose_quiet", o_tx_valid, 0);
`ifdef MP_LINK_RETX_EN
        check("retx_gap1", lose_cyc_q[1] - lose_cyc_q[0], 8);
        check("retx_gap2", lose_cyc_q[2] - lose_cyc_q[1], 8);
`endif
        check("lost_sticky", o_lose, 1);
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        check("rs_idle", o_link_state, 0);
        check("rs_lose", o_lose, 0);

        // simultaneous local loss and received LOSE: loss wins; early restart held
        goto_play();
        base = lose_acc;
        i_tx_ready = 1'b0; i_game_over = 1'b1;
        i_rx_valid = 1'b1; i_rx_data = 8'h4C;
        tick();
        i_game_over = 1'b0; i_rx_valid = 1'b0;
        check("both_state", o_link_state, 4);
        check("both_flags", {o_win, o_lose}, 2'b01);
        check("both_last", o_last_char, 8'h4C);
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        check("pend_hold", o_link_state, 4);
        i_tx_ready = 1'b1;
        wait_state(3'd0, 40, "pend_idle");
        check("pend_lose", o_lose, 0);
        check("pend_count", lose_acc - base, LOSE_EXP);

        // peer loses: other chars only update last_char, READY ignored in PLAY
        goto_play();
        base = tx_acc;
        i_rx_valid = 1'b1; i_rx_data = 8'h41;
        tick();
        check("oth_last", o_last_char, 8'h41);
        check("oth_state", o_link_state, 3);
        i_rx_data = 8'h52;
        tick();
        check("rdy_ignored", o_link_state, 3);
        i_rx_data = 8'h4C;
        tick();
        i_rx_valid = 1'b0;
        check("won_last", o_last_char, 8'h4C);
        check("won_state", o_link_state, 5);
        check("won_flags", {o_win, o_lose}, 2'b10);
        repeat (12) tick();
        check("won_no_tx", tx_acc - base, 0);
        check("won_sticky", {o_win, o_tx_valid}, 2'b10);
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        check("won_rs", {o_link_state, o_win}, 4'b0000);

        // multiplayer drop with a READY mid-handshake
        i_tx_ready = 1'b0;
        tick();
        check("mp_search", {o_link_state, o_tx_valid}, 4'b0011);
        i_multiplayer = 1'b0;
        tick();
        check("mp_idle", o_link_state, 0);
        check("mp_held", {o_tx_valid, o_tx_data}, 9'h152);
        tick();
        check("mp_held2", o_tx_valid, 1);
        base = tx_acc;
        i_tx_ready = 1'b1;
        vsum = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            vsum += o_tx_valid;
        end
        check("mp_one_acc", tx_acc - base, 1);
        check("mp_no_more", vsum, 0);
        check("mp_stay_idle", o_link_state, 0);

        // synchronous reset mid-SEARCH abandons the outstanding READY
        i_multiplayer = 1'b1; i_tx_ready = 1'b0;
        tick();
        check("r2_search", {o_link_state, o_tx_valid}, 4'b0011);
        i_rx_valid = 1'b1; i_rx_data = 8'h33;
        tick();
        i_rx_valid = 1'b0;
        check("r2_last", o_last_char, 8'h33);
        rst = 1'b1;
        tick();
        check("r2_valid", o_tx_valid, 0);
        check("r2_state", o_link_state, 0);
        check("r2_last_clr", o_last_char, 0);
        rst = 1'b0;
        tick();
        check("r2_resume", {o_link_state, o_tx_valid}, 4'b0011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mp_link_ctrl.md
Name: mp_link_ctrl

Overview:
- Parametrised multiplayer link controller. It sits between the game logic (player_ready, game_over) and a UART byte interface that uses a valid/ready transmit side and a strobed receive side.
- It runs a ready-exchange FSM: periodic READY character, wait for the peer's READY, then start the game.
- It reports the game outcome: a local loss sends a LOSE character; a received LOSE is reported as a win.
- Replaces the fixed-message, free-running UART send scheme with explicit handshakes, pacing and sticky outcome states.

Parameters:
- DATA_W, 8: UART character width.
- CHAR_READY, 8'h52: READY character ("R").
- CHAR_LOSE, 8'h4C: LOSE character ("L").
- READY_PERIOD, 100000: clk cycles between READY transmissions while searching; must be ≥2.
- LOSE_REPEAT, 4: total LOSE transmissions when MP_LINK_RETX_EN is defined; must be ≥1.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- multiplayer, input, 1: level; multiplayer mode enable.
- player_ready, input, 1: level; local player waiting for a game.
- game_over, input, 1: local loss; level or pulse.
- restart, input, 1: pulse; leave WON/LOST and return to IDLE.
- tx_data, output, DATA_W: character to send.
- tx_valid, output, 1: transmit request.
- tx_ready, input, 1: UART accepts tx_data when tx_valid && tx_ready.
- rx_data, input, DATA_W: received character.
- rx_valid, input, 1: one-cycle strobe; rx_data valid.
- game_start, output, 1: one-cycle pulse when the match begins.
- win, output, 1: sticky; peer lost.
- lose, output, 1: sticky; local player lost.
- link_state, output, 3: current FSM state encoding.
- last_char, output, DATA_W: last character received on rx_data (display).

Behaviour:
- Reset values: tx_valid=0, tx_data=0, game_start=0, win=0, lose=0, last_char=0, state=IDLE (link_state=0), internal counters and flags cleared. Reset mid-transfer drops tx_valid on the same clock edge; no partial handshake is retained.
- State encodings: IDLE=0, SEARCH=1, START=2, PLAY=3, LOST=4, WON=5.
- last_char loads rx_data on every rx_valid, in every state.
- Transmit handshake: once tx_valid rises, tx_data and tx_valid are held stable until the cycle where tx_ready=1. tx_valid falls the cycle after acceptance. At most one character is outstanding.
- multiplayer=0: next state forced to IDLE from any state; win, lose and pending tx are cleared. If a character is mid-handshake, tx_valid stays high until it is accepted, then no further tx.
- IDLE:
  - player_ready=1 && multiplayer=1 → SEARCH.
  - Pacing counter loaded to 0 so the first READY is requested on the first SEARCH cycle.
- SEARCH:
  - READY is requested when the pacing counter reaches 0; the counter reloads to READY_PERIOD-1 on acceptance and counts down while waiting.
  - rx_valid with rx_data==CHAR_READY sets peer_seen.
  - own_sent is set on any accepted READY that occurs in the same cycle as, or after, peer_seen is set.
  - peer_seen && own_sent → START.
  - player_ready=0 → IDLE; flags cleared.
- START: game_start=1 for exactly one cycle → PLAY.
- PLAY:
  - Received READY characters are ignored.
  - game_over=1 → LOST: lose=1, one LOSE character queued.
  - rx_valid && rx_data==CHAR_LOSE → WON: win=1.
  - If both occur in the same cycle, the local loss has priority: go to LOST; the received LOSE is ignored.
- LOST:
  - Sends the queued LOSE character(s); see Optional Feature.
  - lose stays 1. Stays until restart=1 (after all LOSE sends are accepted) or multiplayer=0 → IDLE.
  - restart before the sends complete is held pending and applied after the last acceptance.
- WON: no transmission; win stays 1. restart=1 or multiplayer=0 → IDLE.
- Any received character other than CHAR_READY/CHAR_LOSE affects only last_char.
- Pacing counter width is $clog2(READY_PERIOD); it saturates at 0 and never wraps.

Optional Feature:
- MP_LINK_RETX_EN defined: in LOST, LOSE is sent LOSE_REPEAT times. Consecutive requests are spaced READY_PERIOD cycles apart, measured from the previous acceptance. A repeat counter tracks the number of sends.
- Not defined: LOSE is sent exactly once; LOSE_REPEAT is unused.

Test Plan:
- Reset with READY_PERIOD=8, multiplayer=1, player_ready=1, tx_ready=1 → first cycle after reset release: IDLE; next: SEARCH, tx_valid=1, tx_data=8'h52. READY accepted every 8 cycles; link_state=1.
- In SEARCH, inject rx 8'h52 → after the next accepted READY: one-cycle game_start, link_state 2→3.
- In PLAY, pulse game_over, tx_ready=0 for 5 cycles → tx_data=8'h4C held with tx_valid=1 throughout; accepted on the first tx_ready=1; lose=1; link_state=4.
- In PLAY, game_over=1 and rx 8'h4C in the same cycle → LOST, lose=1, win=0; then restart → IDLE, lose=0.
- In PLAY, rx 8'h41 then 8'h4C → last_char=8'h41 then 8'h4C, win=1, link_state=5, no tx activity. With MP_LINK_RETX_EN and LOSE_REPEAT=3, a local loss gives exactly 3 LOSE acceptances 8 cycles apart.
- Deassert multiplayer during SEARCH with tx_ready=0 → tx_valid held until one acceptance, then state IDLE, no further tx. Asserting rst mid-SEARCH → tx_valid=0 on the next edge.
